uart_sync_fifo: RTL and testbench
=================================

// Module: uart_sync_fifo
// PURPOSE
//  Parametrised synchronous FIFO; successor to the 16x8 UART buffer. Sits between the UART
//  byte interface (rx deserialiser / tx serialiser) and the host side. Adds configurable
//  width, depth and thresholds, an occupancy count, flush, and sticky overflow/underflow
//  errors. Optional baud_trig qualification of both ports.
// PARAMETERS
//  DATA_W    8   data word width in bits
//  DEPTH     16  entries; power of two, >= 4
//  AF_LVL    12  almost_full asserted when count >= AF_LVL (1..DEPTH-1)
//  AE_LVL    2   almost_empty asserted when count <= AE_LVL (0..DEPTH-1)
//  USE_TRIG  1   1: writes/reads accepted only in cycles with baud_trig=1; 0: baud_trig ignored
// PORTS
//  clk           in   1          rising-edge clock
//  rst           in   1          synchronous, active-high reset
//  baud_trig     in   1          baud-rate enable strobe (see USE_TRIG)
//  flush         in   1          synchronous clear of contents
//  wr_en         in   1          write request
//  data_in       in   DATA_W     write data
//  wr_ack        out  1          write accepted this cycle (registered, 1-cycle pulse)
//  rd_en         in   1          read request
//  data_out      out  DATA_W     read data, registered
//  rd_valid      out  1          data_out updated this cycle (1-cycle pulse)
//  full          out  1          count == DEPTH
//  empty         out  1          count == 0
//  almost_full   out  1          count >= AF_LVL
//  almost_empty  out  1          count <= AE_LVL
//  count         out  CW         occupancy, CW = $clog2(DEPTH)+1
//  overflow      out  1          sticky: write attempted (qualified) while full
//  underflow     out  1          sticky: read attempted (qualified) while empty
//  err_clr       in   1          clears overflow/underflow
// BEHAVIOUR
//  - Reset: pointers=0, count=0, data_out=0, wr_ack=0, rd_valid=0, overflow=underflow=0;
//    empty=1, full=0, almost_empty=1, almost_full=0. Memory contents not cleared.
//  - trig = USE_TRIG ? baud_trig : 1. wr_go = wr_en & trig & ~full; rd_go = rd_en & trig & ~empty.
//    full/empty are evaluated on the pre-edge state (no same-cycle pass-through).
//  - Pointers CW bits wide (extra wrap bit); index = low $clog2(DEPTH) bits; natural wrap
//    DEPTH-1 -> 0. full when indices equal and wrap bits differ; empty when fully equal.
//  - count: +1 on wr_go only, -1 on rd_go only, unchanged on both; never exceeds DEPTH.
//  - Write: on wr_go, mem[wr_idx] <= data_in, wr_ptr++ ; wr_ack=1 next cycle.
//  - Read latency 1: on rd_go, data_out <= mem[rd_idx], rd_ptr++, rd_valid=1 next cycle;
//    otherwise data_out holds its value, rd_valid=0.
//  - Full + wr_en + rd_en (trig): read proceeds, write rejected, overflow set.
//  - Empty + wr_en + rd_en (trig): write proceeds, read rejected, underflow set; no
//    fall-through: the written word is readable from the next cycle.
//  - Non-trig cycles: no accepts, no error flags, outputs hold except pulses drop to 0.
//  - Sticky flags: set on rejected qualified request; err_clr clears; set wins over clr
//    in the same cycle.
//  - flush: next cycle pointers=0, count=0, wr_ack=rd_valid=0; overrides any same-cycle
//    wr_go/rd_go; data_out and sticky flags hold. rst has priority over flush.
//  - All status outputs (full..almost_empty, count) are registered / derived from registers;
//    no combinational path from inputs to outputs.
// STRUCTURE
//  - uart_fifo_pkg: default constants (DATA_W_DEF=8, DEPTH_DEF=16), function
//    clog2-based CW helper, elaboration checks (DEPTH power of two, AF_LVL/AE_LVL ranges).
//  - Sub-module uart_fifo_mem: simple dual-port RAM, 1 write port, 1 registered read port,
//    DATA_W x DEPTH, no reset on array. Top holds pointers, count, flags, control.
// TESTING
//  - Reset then fill: 16 writes 0x01..0x10 with trig each cycle -> count 16, full=1,
//    almost_full from 12th write, wr_ack 16 pulses; 17th write -> rejected, overflow=1.
//  - Drain: 16 reads -> data_out 0x01..0x10 in order, each 1 cycle after rd_go, empty=1
//    after last; extra read -> underflow=1, data_out stays 0x10.
//  - Wrap: write 10, read 10, write 12, read 12 -> order preserved across index 15->0,
//    count returns to 0.
//  - Simultaneous: at count 5, wr_en=rd_en=1 for 4 trig cycles -> count stays 5, FIFO order
//    intact; at full same stimulus -> count 16->15, overflow set.
//  - USE_TRIG=1: wr_en held 8 cycles with baud_trig every 4th cycle -> exactly 2 accepts;
//    USE_TRIG=0 same stimulus -> 8 accepts.
//  - flush at count 7 with concurrent wr_en -> count 0, empty=1, write dropped; rst
//    asserted mid-burst -> all outputs at reset values next cycle; err_clr clears flags.

Source files
------------

// File: rtl/uart_fifo_pkg.sv
// Shared constants and parameter helpers for the UART synchronous FIFO.
package uart_fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  // Pointer/count width: one bit more than the index so that full and empty
  // can be told apart when the indices match.
  function automatic int fifo_cw(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Legal configuration: power-of-two depth of at least 4, with both
  // thresholds inside the occupancy range.
  function automatic bit fifo_params_ok(input int depth, input int af_lvl, input int ae_lvl);
    return (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (af_lvl >= 1) && (af_lvl <= depth - 1) &&
           (ae_lvl >= 0) && (ae_lvl <= depth - 1);
  endfunction

endpackage

// File: rtl/uart_sync_fifo_if.sv
// Host/UART-side bundle of the FIFO: request strobes, data, status and error flags.
interface uart_sync_fifo_if
  import uart_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CW     = fifo_cw(DEPTH_DEF)
) ();

  logic              baud_trig;
  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] data_in;
  logic              wr_ack;
  logic              rd_en;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;
  logic              err_clr;

  // The side that issues requests (host logic or UART datapath).
  modport master (
    output baud_trig, flush, wr_en, data_in, rd_en, err_clr,
    input  wr_ack, data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  // The FIFO itself.
  modport slave (
    input  baud_trig, flush, wr_en, data_in, rd_en, err_clr,
    output wr_ack, data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage: one write port, one registered read port.
// The array itself is never reset so it maps onto block RAM; only the
// read output register is cleared.
module uart_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DATA_W-1:0] rd_data_reg;

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holds its last word when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/uart_sync_fifo.sv
// Parametrised synchronous FIFO between the UART byte datapath and the host.
// Holds pointers, occupancy count, pulses and sticky error flags; storage
// lives in uart_fifo_mem.
module uart_sync_fifo
  import uart_fifo_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AF_LVL   = 12,
  parameter int AE_LVL   = 2,
  parameter int USE_TRIG = 1
) (
  input logic             clk,
  input logic             rst,
  uart_sync_fifo_if.slave bus
);

  localparam int CW = fifo_cw(DEPTH);
  localparam int IW = CW - 1;
  localparam logic [CW-1:0] AF_C = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_C = CW'(AE_LVL);

  if (!fifo_params_ok(DEPTH, AF_LVL, AE_LVL)) begin : g_bad_params
    $error("uart_sync_fifo: illegal DEPTH/AF_LVL/AE_LVL combination");
  end

  logic [CW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          wr_ack_reg, wr_ack_next;
  logic          rd_valid_reg, rd_valid_next;
  logic          ovf_reg, ovf_next;
  logic          udf_reg, udf_next;

  logic trig, full, empty, wr_req, rd_req, wr_go, rd_go;

  // Request qualification on the pre-edge state; flush suppresses any transfer.
  always_comb begin
    trig   = (USE_TRIG != 0) ? bus.baud_trig : 1'b1;
    full   = (wr_ptr_reg[IW-1:0] == rd_ptr_reg[IW-1:0]) && (wr_ptr_reg[IW] != rd_ptr_reg[IW]);
    empty  = (wr_ptr_reg == rd_ptr_reg);
    wr_req = bus.wr_en & trig;
    rd_req = bus.rd_en & trig;
    wr_go  = wr_req & ~full & ~bus.flush;
    rd_go  = rd_req & ~empty & ~bus.flush;
  end

  // Next-state for pointers, occupancy, pulses and sticky flags.
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    wr_ack_next   = wr_go;
    rd_valid_next = rd_go;
    ovf_next      = ovf_reg;
    udf_next      = udf_reg;
    if (bus.flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (wr_go) wr_ptr_next = wr_ptr_reg + CW'(1);
      if (rd_go) rd_ptr_next = rd_ptr_reg + CW'(1);
      case ({wr_go, rd_go})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
      // A new error in the same cycle as err_clr stays visible.
      ovf_next = (ovf_reg & ~bus.err_clr) | (wr_req & full);
      udf_next = (udf_reg & ~bus.err_clr) | (rd_req & empty);
    end
  end

  // State registers; reset beats flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      wr_ack_reg   <= 1'b0;
      rd_valid_reg <= 1'b0;
      ovf_reg      <= 1'b0;
      udf_reg      <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      wr_ack_reg   <= wr_ack_next;
      rd_valid_reg <= rd_valid_next;
      ovf_reg      <= ovf_next;
      udf_reg      <= udf_next;
    end
  end

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (IW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_go),
    .wr_addr (wr_ptr_reg[IW-1:0]),
    .wr_data (bus.data_in),
    .rd_en   (rd_go),
    .rd_addr (rd_ptr_reg[IW-1:0]),
    .rd_data (bus.data_out)
  );

  assign bus.wr_ack       = wr_ack_reg;
  assign bus.rd_valid     = rd_valid_reg;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_reg >= AF_C);
  assign bus.almost_empty = (count_reg <= AE_C);
  assign bus.count        = count_reg;
  assign bus.overflow     = ovf_reg;
  assign bus.underflow    = udf_reg;

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Randomised and directed bench for uart_sync_fifo against a queue-based model.
module tb_uart_sync_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CW     = 5;
  localparam int AF_LVL = 12;
  localparam int AE_LVL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_sync_fifo_if #(.DATA_W(DATA_W), .CW(CW)) if_t ();
  uart_sync_fifo_if #(.DATA_W(DATA_W), .CW(CW)) if_n ();

  uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL), .USE_TRIG(1))
    dut_t (.clk(clk), .rst(rst), .bus(if_t));
  uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL), .USE_TRIG(0))
    dut_n (.clk(clk), .rst(rst), .bus(if_n));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t_acks = 0;
  int n_acks = 0;
  bit n_en = 1'b0;

  // Reference model: FIFO contents as a queue plus the observable registers.
  logic [7:0] mq[$];
  logic [7:0] m_dout = '0;
  bit m_ack = 0, m_valid = 0, m_ovf = 0, m_udf = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: drive at negedge, advance model, sample 1ns after posedge.
  task automatic step(input bit r, input bit wr, input logic [7:0] din, input bit rd,
                      input bit trig, input bit fl, input bit ec);
    bit full_m, empty_m, wreq, rreq;
    int sz;
    @(negedge clk);
    rst = r;
    if_t.wr_en = wr; if_t.data_in = din; if_t.rd_en = rd;
    if_t.baud_trig = trig; if_t.flush = fl; if_t.err_clr = ec;
    if_n.wr_en = wr & n_en; if_n.data_in = din; if_n.baud_trig = trig;
    if (r) begin
      mq.delete(); m_dout = '0; m_ack = 0; m_valid = 0; m_ovf = 0; m_udf = 0;
    end else if (fl) begin
      mq.delete(); m_ack = 0; m_valid = 0;
    end else begin
      full_m  = (mq.size() == DEPTH);
      empty_m = (mq.size() == 0);
      wreq = wr && trig;
      rreq = rd && trig;
      m_valid = rreq && !empty_m;
      if (m_valid) m_dout = mq.pop_front();
      m_ack = wreq && !full_m;
      if (m_ack) mq.push_back(din);
      if (ec) begin m_ovf = 0; m_udf = 0; end
      if (wreq && full_m) m_ovf = 1;
      if (rreq && empty_m) m_udf = 1;
    end
    cyc++;
    @(posedge clk);
    #1;
    sz = mq.size();
    check_val("count",        32'(if_t.count),        32'(sz));
    check_val("full",         32'(if_t.full),         32'(sz == DEPTH));
    check_val("empty",        32'(if_t.empty),        32'(sz == 0));
    check_val("almost_full",  32'(if_t.almost_full),  32'(sz >= AF_LVL));
    check_val("almost_empty", 32'(if_t.almost_empty), 32'(sz <= AE_LVL));
    check_val("wr_ack",       32'(if_t.wr_ack),       32'(m_ack));
    check_val("rd_valid",     32'(if_t.rd_valid),     32'(m_valid));
    check_val("data_out",     32'(if_t.data_out),     32'(m_dout));
    check_val("overflow",     32'(if_t.overflow),     32'(m_ovf));
    check_val("underflow",    32'(if_t.underflow),    32'(m_udf));
    if (if_t.wr_ack) t_acks++;
    if (n_en && if_n.wr_ack) n_acks++;
    $display("cyc %0d rst=%0b wr=%0b din=%02h rd=%0b trig=%0b fl=%0b ec=%0b -> cnt=%0d dout=%02h ovf=%0b udf=%0b",
             cyc, r, wr, din, rd, trig, fl, ec, if_t.count, if_t.data_out, if_t.overflow, if_t.underflow);
  endtask

  task automatic wr1(input logic [7:0] d);
    step(0, 1, d, 0, 1, 0, 0);
  endtask

  task automatic rd1();
    step(0, 0, 8'h00, 1, 1, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    if_t.wr_en = 0; if_t.data_in = '0; if_t.rd_en = 0; if_t.baud_trig = 0; if_t.flush = 0; if_t.err_clr = 0;
    if_n.wr_en = 0; if_n.data_in = '0; if_n.rd_en = 0; if_n.baud_trig = 0; if_n.flush = 0; if_n.err_clr = 0;

    // Reset.
    step(1, 0, 8'h00, 0, 0, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0, 0);
    check_val("rst_empty", 32'(if_t.empty), 32'd1);
    check_val("rst_almost_empty", 32'(if_t.almost_empty), 32'd1);

    // Fill 0x01..0x10, then one rejected write.
    t_acks = 0;
    for (int i = 1; i <= DEPTH; i++) wr1(8'(i));
    check_val("fill_acks", 32'(t_acks), 32'd16);
    check_val("fill_full", 32'(if_t.full), 32'd1);
    wr1(8'hAA);
    check_val("fill_overflow", 32'(if_t.overflow), 32'd1);

    // Drain in order, then one rejected read; then clear flags.
    for (int i = 1; i <= DEPTH; i++) begin
      rd1();
      check_val("drain_order", 32'(if_t.data_out), 32'(i));
    end
    rd1();
    check_val("drain_hold", 32'(if_t.data_out), 32'h10);
    check_val("drain_underflow", 32'(if_t.underflow), 32'd1);
    step(0, 0, 8'h00, 0, 1, 0, 1);
    check_val("err_clr", 32'({if_t.overflow, if_t.underflow}), 32'd0);

    // Wrap the indices past 15 -> 0.
    for (int i = 0; i < 10; i++) wr1(8'($urandom_range(0, 255)));
    for (int i = 0; i < 10; i++) rd1();
    for (int i = 0; i < 12; i++) wr1(8'($urandom_range(0, 255)));
    for (int i = 0; i < 12; i++) rd1();
    check_val("wrap_count", 32'(if_t.count), 32'd0);

    // Simultaneous read/write at count 5, then at full.
    for (int i = 0; i < 5; i++) wr1(8'($urandom_range(0, 255)));
    for (int i = 0; i < 4; i++) step(0, 1, 8'($urandom_range(0, 255)), 1, 1, 0, 0);
    check_val("simul_count5", 32'(if_t.count), 32'd5);
    for (int i = 0; i < 11; i++) wr1(8'($urandom_range(0, 255)));
    step(0, 1, 8'hC3, 1, 1, 0, 0);
    check_val("simul_full_count", 32'(if_t.count), 32'd15);
    check_val("simul_full_ovf", 32'(if_t.overflow), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 1, 8'($urandom_range(0, 255)), 1, 1, 0, 0);
    while (if_t.count != 0 && cyc < 2000) rd1();
    step(0, 0, 8'h00, 0, 1, 0, 1);

    // Trigger qualification: strobe every 4th cycle over 8 cycles of wr_en.
    t_acks = 0; n_acks = 0; n_en = 1;
    for (int i = 0; i < 8; i++) step(0, 1, 8'($urandom_range(0, 255)), 0, (i % 4) == 3, 0, 0);
    n_en = 0;
    check_val("trig_accepts", 32'(t_acks), 32'd2);
    check_val("notrig_accepts", 32'(n_acks), 32'd8);
    check_val("notrig_count", 32'(if_n.count), 32'd8);
    rd1(); rd1();

    // Flush at count 7 with a concurrent write.
    for (int i = 0; i < 7; i++) wr1(8'($urandom_range(0, 255)));
    step(0, 1, 8'h5A, 0, 1, 1, 0);
    check_val("flush_count", 32'(if_t.count), 32'd0);
    check_val("flush_empty", 32'(if_t.empty), 32'd1);

    // Reset in the middle of a write burst.
    for (int i = 0; i < 3; i++) wr1(8'($urandom_range(0, 255)));
    rd1();
    step(1, 1, 8'h77, 1, 1, 0, 0);
    check_val("rst_mid_count", 32'(if_t.count), 32'd0);
    check_val("rst_mid_dout", 32'(if_t.data_out), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < 55),
           8'($urandom_range(0, 255)),
           ($urandom_range(0, 99) < 50),
           ($urandom_range(0, 99) < 75),
           ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 99) < 5));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
